memory_cycle: RTL
=================

Name: memory_cycle

Overview:
- MEM stage of the 5-stage RV32I pipeline; sits between the execute stage and the writeback stage.
- Holds the data memory and performs byte, halfword and word loads/stores selected by funct3, with sign or zero extension.
- Contains the MEM/WB pipeline register. Its registered outputs drive the writeback stage directly: ResultSrcW, ALUOutW, ReadDataW and PCPlus4W, plus RegWriteW, RDW and MisalignW for the register file and hazard unit.

Parameters:
- DEPTH, 64, number of 32-bit words in data memory; must be a power of 2; word index = ALUResultM[log2(DEPTH)+1:2].

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RegWriteM  input  1  register-file write enable from EX/MEM.
- MemWriteM  input  1  store enable.
- ResultSrcM  input  1  0 = ALU result, 1 = load data.
- funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RDM  input  5  destination register.
- ALUResultM  input  32  effective address / ALU result.
- WriteDataM  input  32  store data; low bits used for B/H.
- PCPlus4M  input  32  PC+4 passthrough.
- RegWriteW  output  1  registered RegWriteM.
- ResultSrcW  output  1  registered ResultSrcM.
- RDW  output  5  registered RDM.
- ALUOutW  output  32  registered ALUResultM.
- ReadDataW  output  32  registered, extended load data.
- PCPlus4W  output  32  registered PCPlus4M.
- MisalignW  output  1  registered misaligned or illegal-access flag.

Behaviour:
- Reset (asynchronous, rst=1): all W outputs go to 0 immediately, and every memory word is cleared to 0. Outputs stay at 0 while rst is held.
- Alignment:
  - addr = ALUResultM; off = addr[1:0].
  - H/HU is misaligned if off[0]=1. W is misaligned if off != 0. B/BU is never misaligned.
  - Misaligned flag asserts only when MemWriteM=1 or ResultSrcM=1.
- Read path:
  - Combinational read of word mem[idx], then lane select by off.
  - B: sign-extend byte (off*8+7 : off*8). BU: zero-extend the same byte.
  - H: sign-extend halfword at off[1]*16. HU: zero-extend it. W: full word.
  - Misaligned or illegal funct3 (011, 110, 111) gives load data 0.
- Write path:
  - On posedge with MemWriteM=1 and the access legal and aligned, write the byte lanes only.
  - SB writes WriteDataM[7:0] to lane off. SH writes WriteDataM[15:0] to lanes off[1]*2 and +1. SW writes all 4 lanes. Other lanes are unchanged.
  - Misaligned or illegal store: memory unchanged. RegWriteM passes through unmodified.
- Address wrap: bits above the index range are ignored; an address of DEPTH*4 aliases word 0.
- Latency:
  - Every M input appears on its W output exactly 1 cycle later. ReadDataW reflects memory contents before that same edge's store.
  - A store in cycle N followed by a load to the same address in cycle N+1 returns the new data (no stale read).
- No stall or flush inputs: the register captures every cycle, and bubbles arrive as all-zero control from upstream.
- Reset mid-operation: a store present at the edge when rst asserts is not performed. The first capture happens on the first posedge after rst deasserts.
- MisalignW is 1 for a misaligned or illegal access. Upstream handles the trap; this block only suppresses the access.

Test Plan:
- Reset: hold rst, then deassert. All W outputs = 0; LW from 0x0, 0x4 and 0xFC returns ReadDataW = 0.
- Word store/load: SW 0xDEADBEEF @0x10, next cycle LW @0x10. ReadDataW = 0xDEADBEEF one cycle later; ResultSrcW=1, RDW echoes RDM.
- Byte lanes: SW 0x11223344 @0x20, then SB 0xAA @0x21. LW @0x20 gives 0x1122AA44; LB @0x21 gives 0xFFFFFFAA; LBU @0x21 gives 0x000000AA.
- Halfword: SH 0x8001 @0x32. LH @0x32 gives 0xFFFF8001; LHU @0x32 gives 0x00008001; LW @0x30 has the upper half = 0x8001.
- Misaligned and illegal:
  - SW 0x12345678 @0x41: memory unchanged, MisalignW=1.
  - LH @0x43: ReadDataW=0, MisalignW=1.
  - Illegal funct3 011 store: memory unchanged, MisalignW=1.
- Wrap and passthrough (DEPTH=64): SW 0x5 @0x100 aliases word 0, so LW @0x0 returns 5. An ALU op (ResultSrcM=0, RegWriteM=1, ALUResultM=0x7) gives ALUOutW=0x7 and PCPlus4W = PCPlus4M after 1 cycle.

Source files
------------

// File: rtl/memory_cycle.sv
// -----------------------------------------------------------------------------
// memory_cycle : MEM stage of the 5-stage RV32I pipeline.
//
// Holds the data memory (DEPTH x 32-bit words, byte-lane writable), performs
// B/H/W loads and stores selected by funct3 with sign/zero extension, and
// contains the MEM/WB pipeline register whose outputs feed writeback, the
// register file and the hazard unit.
//
// Ports:
//   clk         pipeline clock, rising edge
//   rst         asynchronous active-high reset (clears W outputs and memory)
//   RegWriteM   register-file write enable from EX/MEM
//   MemWriteM   store enable
//   ResultSrcM  0 = ALU result, 1 = load data
//   funct3M     000 B, 001 H, 010 W, 100 BU, 101 HU (others illegal)
//   RDM         destination register
//   ALUResultM  effective address / ALU result
//   WriteDataM  store data (low bits used for B/H)
//   PCPlus4M    PC+4 passthrough
//   RegWriteW, ResultSrcW, RDW, ALUOutW, PCPlus4W : registered M inputs
//   ReadDataW   registered, extended load data
//   MisalignW   registered misaligned / illegal-access flag
// -----------------------------------------------------------------------------
module memory_cycle #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        ResultSrcM,
   input  logic [2:0]  funct3M,
   input  logic [4:0]  RDM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus4M,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [4:0]  RDW,
   output logic [31:0] ALUOutW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W,
   output logic        MisalignW
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic [31:0]   rd_word;
   logic          legal;
   logic          misaligned;
   logic          bad_access;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   load_data;
   logic          store_en;
   logic [3:0]    store_be;
   logic [31:0]   store_data;

   logic          reg_write_q,   reg_write_d;
   logic          result_src_q,  result_src_d;
   logic [4:0]    rd_q,          rd_d;
   logic [31:0]   alu_out_q,     alu_out_d;
   logic [31:0]   read_data_q,   read_data_d;
   logic [31:0]   pc_plus4_q,    pc_plus4_d;
   logic          misalign_q,    misalign_d;

   // Upper address bits beyond the index range are ignored, so addresses wrap.
   assign idx     = ALUResultM[AW+1:2];
   assign off     = ALUResultM[1:0];
   assign rd_word = mem_q[idx];

   // Access decode: legality, alignment, lane selection and store enables.
   always_comb begin
      legal      = 1'b1;
      misaligned = 1'b0;
      case (funct3M)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = off[0];
         3'b010:         misaligned = (off != 2'b00);
         default:        legal      = 1'b0;
      endcase
      bad_access = !legal || misaligned;

      case (off)
         2'd0:    sel_byte = rd_word[7:0];
         2'd1:    sel_byte = rd_word[15:8];
         2'd2:    sel_byte = rd_word[23:16];
         default: sel_byte = rd_word[31:24];
      endcase
      sel_half = off[1] ? rd_word[31:16] : rd_word[15:0];

      load_data = 32'd0;
      if (!bad_access) begin
         case (funct3M)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'd0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'd0, sel_half};
            3'b010:  load_data = rd_word;
            default: load_data = 32'd0;
         endcase
      end

      // Store data is replicated across lanes so the byte enables alone pick
      // which lanes change.
      store_be   = 4'b0000;
      store_data = WriteDataM;
      case (funct3M)
         3'b000: begin
            store_be   = 4'b0001 << off;
            store_data = {4{WriteDataM[7:0]}};
         end
         3'b001: begin
            store_be   = off[1] ? 4'b1100 : 4'b0011;
            store_data = {2{WriteDataM[15:0]}};
         end
         3'b010:  store_be = 4'b1111;
         default: store_be = 4'b0000;
      endcase
      store_en = MemWriteM && !bad_access;
   end

   // Data memory: byte-lane writes, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (store_be[b]) begin
               mem_q[idx][b*8 +: 8] <= store_data[b*8 +: 8];
            end
         end
      end
   end

   // MEM/WB register next values.
   always_comb begin
      reg_write_d  = RegWriteM;
      result_src_d = ResultSrcM;
      rd_d         = RDM;
      alu_out_d    = ALUResultM;
      read_data_d  = load_data;
      pc_plus4_d   = PCPlus4M;
      // Flag only matters for real memory accesses.
      misalign_d   = bad_access && (MemWriteM || ResultSrcM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         rd_q         <= 5'd0;
         alu_out_q    <= 32'd0;
         read_data_q  <= 32'd0;
         pc_plus4_q   <= 32'd0;
         misalign_q   <= 1'b0;
      end else begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         rd_q         <= rd_d;
         alu_out_q    <= alu_out_d;
         read_data_q  <= read_data_d;
         pc_plus4_q   <= pc_plus4_d;
         misalign_q   <= misalign_d;
      end
   end

   assign RegWriteW  = reg_write_q;
   assign ResultSrcW = result_src_q;
   assign RDW        = rd_q;
   assign ALUOutW    = alu_out_q;
   assign ReadDataW  = read_data_q;
   assign PCPlus4W   = pc_plus4_q;
   assign MisalignW  = misalign_q;

endmodule
